// File: rtl/byte_mem_requester.sv
// byte_mem_requester
// Initiator side of the byte-wide data-memory port. One 32-bit load or store
// from the MEM stage becomes four big-endian byte beats, and the pipeline is
// held until the last beat is accepted.

module byte_mem_requester #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_write;
  logic [DATA_W-1:0] asm_q;
  logic              in_xfer;
  logic [7:0]        beat_byte;

  // Sequencer: capture the request in IDLE, step one beat per accepted
  // cycle in XFER, and spend exactly one cycle in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
      asm_q    <= '0;
      rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_write || req_read) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            op_write <= req_write;
            beat     <= 2'd0;
            asm_q    <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (mem_ready) begin
            if (!op_write) begin
              case (beat)
                2'd0:    asm_q[31:24] <= mem_rdata;
                2'd1:    asm_q[23:16] <= mem_rdata;
                2'd2:    asm_q[15:8]  <= mem_rdata;
                default: asm_q[7:0]   <= mem_rdata;
              endcase
            end
            if (beat == 2'd3) begin
              state <= DONE;
              if (!op_write) begin
                rdata <= {asm_q[31:8], mem_rdata};
              end
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Big-endian byte select of the captured store word for the current beat.
  always_comb begin
    beat_byte = 8'h00;
    case (beat)
      2'd0:    beat_byte = wdata_q[31:24];
      2'd1:    beat_byte = wdata_q[23:16];
      2'd2:    beat_byte = wdata_q[15:8];
      default: beat_byte = wdata_q[7:0];
    endcase
  end

  // Memory-side outputs are only live in XFER; stall covers the request
  // cycle itself so the pipeline never advances past an unaccepted access.
  always_comb begin
    in_xfer   = (state == XFER);
    mem_re    = in_xfer && !op_write;
    mem_we    = in_xfer && op_write;
    mem_addr  = in_xfer ? (addr_q + {{(ADDR_W-2){1'b0}}, beat}) : '0;
    mem_wdata = (in_xfer && op_write) ? beat_byte : 8'h00;
    done      = (state == DONE);
    stall     = !rst && (in_xfer || ((state == IDLE) && (req_read || req_write)));
  end

endmodule
